parity_stream_engine: RTL
=========================

Name: parity_stream_engine

Overview:
Parametrised, streaming parity generator/checker; successor to the single-byte parity block. Splits each DATA_W-bit beat into LANE_W-bit lanes and computes per-lane parity, even or odd. In generate mode it appends parity bits; in check mode it flags mismatches and keeps a sticky flag plus a saturating error counter. Sits between any valid/ready producer and consumer on datapath links, with one register stage.

Parameters:
DATA_W, 32, beat width in bits; must be an integer multiple of LANE_W.
LANE_W, 8, bits covered by one parity bit.
CNT_W, 16, width of the error counter.
(derived) LANES = DATA_W/LANE_W.

Ports:
clk  in  1  clock; all logic is rising-edge triggered.
rst_n  in  1  asynchronous reset, active-low.
cfg_odd  in  1  0 = even parity, 1 = odd parity; sampled on each accepted beat.
cfg_check  in  1  0 = generate mode, 1 = check mode; sampled on each accepted beat.
clr_err  in  1  synchronous clear of err_sticky and err_count.
in_valid  in  1  upstream beat valid.
in_ready  out  1  block can accept a beat.
in_data  in  DATA_W  beat data; lane k = in_data[k*LANE_W +: LANE_W].
in_par  in  LANES  received parity bits, one per lane; used only in check mode.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts the beat.
out_data  out  DATA_W  registered copy of in_data.
out_par  out  LANES  generated parity (generate mode) or in_par passed through (check mode).
out_err  out  LANES  per-lane mismatch flags; always 0 in generate mode.
err_sticky  out  1  set by any erroneous beat; held until clr_err.
err_count  out  CNT_W  number of accepted beats with at least one lane error; saturates.

Behaviour:
- Reset (rst_n=0, async): out_valid=0; out_data, out_par, out_err, err_sticky, err_count all 0. in_ready=1 from the first cycle after release.
- Handshake: accept when in_valid && in_ready. Transfer out when out_valid && out_ready. in_ready = !out_valid || out_ready (combinational).
- Latency is 1 cycle. Throughput is one beat per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_data, out_par and out_err stay stable. No beat is dropped or duplicated.
- If out_valid transfers and no new beat is accepted in the same cycle, out_valid goes to 0.
- Lane parity: p[k] = XOR of lane k bits, XOR cfg_odd.
- Generate mode: out_par[k] = p[k]; out_err = 0.
- Check mode: out_par = in_par; out_err[k] = in_par[k] XOR p[k].
- Beat error: a beat is in error when it is accepted in check mode and out_err is nonzero. Counting happens at acceptance, once per beat regardless of how many lanes fail.
- Error beat effect: err_sticky <= 1; err_count increments by 1. At all-ones, err_count holds.
- clr_err alone: err_sticky <= 0, err_count <= 0.
- clr_err in the same cycle as an error beat: err_count <= 1, err_sticky <= 1 (the new event is kept).
- Config changes take effect only on the next accepted beat. A beat already registered is unaffected.
- Reset during a stall discards the held beat.

Test Plan:
- Generate mode, cfg_odd=0, in_data=0x01030700 (DATA_W=32, LANE_W=8) -> out_par=4'b1010 one cycle later, out_err=0. With cfg_odd=1, same data -> out_par=4'b0101.
- Check mode, even, in_data=0xFF00FF01, in_par=4'b0000 -> out_err=4'b0001, err_sticky=1, err_count=1. Then in_par=4'b0001 on the same data -> out_err=0, err_count stays 1.
- Backpressure: stream 4 beats with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, out_* held stable, all 4 beats delivered exactly once and in order.
- Saturation, CNT_W=4: 20 consecutive erroring beats -> err_count=15 and holds.
- clr_err alone -> err_count=0, err_sticky=0. clr_err together with an erroring beat -> err_count=1, err_sticky=1.
- Assert rst_n low while out_valid=1 and out_ready=0 -> all outputs 0 immediately. After release, in_ready=1 and the next beat is processed normally at full rate.

Source files
------------

// File: rtl/parity_stream_engine_if.sv
// rtl/parity_stream_engine_if.sv - beat handshake bundle between producer, engine and consumer
interface parity_stream_engine_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LANES-1:0]  in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LANES-1:0]  out_par;
  logic [LANES-1:0]  out_err;

  modport master (
    output in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, out_par, out_err
  );

  modport slave (
    input  in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, out_par, out_err
  );
endinterface

// File: rtl/parity_stream_engine.sv
// rtl/parity_stream_engine.sv - per-lane parity generate/check with one register stage
module parity_stream_engine #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_odd,
  input  logic                 cfg_check,
  input  logic                 clr_err,
  parity_stream_engine_if.slave bus,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     err_count
);
  localparam int LANES = DATA_W / LANE_W;

  logic [LANES-1:0] lane_par;
  logic [LANES-1:0] beat_err;
  logic             accept;
  logic             beat_bad;

  always_comb begin
    lane_par = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_par[k] = (^bus.in_data[k*LANE_W +: LANE_W]) ^ cfg_odd;
    end
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign beat_err     = cfg_check ? (bus.in_par ^ lane_par) : '0;
  // Errors are counted at acceptance, so a stalled beat is never counted twice.
  assign beat_bad     = accept && (|beat_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_par   <= '0;
      bus.out_err   <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data;
      bus.out_par   <= cfg_check ? bus.in_par : lane_par;
      bus.out_err   <= beat_err;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // A clear coinciding with an error beat keeps that new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (clr_err) begin
      err_sticky <= beat_bad;
      err_count  <= beat_bad ? CNT_W'(1) : '0;
    end else if (beat_bad) begin
      err_sticky <= 1'b1;
      if (!(&err_count)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end
endmodule
